// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle sequencer.
//   - opcode values of the supported MIPS subset
//   - FSM state encoding, ALU-op codes and trap-cause codes
//   - ctrl_t: registered datapath/handshake control bundle
//   - op_legal / ctrl_decode: opcode legality and per-state control decode
package mc_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TMO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TMO = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       trap;
    } ctrl_t;

    // Opcode legality; bne is legal only when enabled.
    function automatic logic op_legal(input logic [OP_W-1:0] op, input logic en_bne);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            OP_BNE:  legal = en_bne;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Moore control decode of a state and the latched opcode.
    function automatic ctrl_t ctrl_decode(input state_e st, input logic [OP_W-1:0] op);
        ctrl_t c;
        logic  in_dp;
        c     = '0;
        in_dp = (st == ST_EXEC) || (st == ST_MEM) || (st == ST_WB);
        if (in_dp) begin
            c.reg_dst    = (op == OP_RTYPE);
            c.alu_src    = (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI);
            c.mem_to_reg = (op == OP_LW);
            if (op == OP_RTYPE) begin
                c.alu_op = ALU_FUNCT;
            end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
                c.alu_op = ALU_SUB;
            end else begin
                c.alu_op = ALU_ADD;
            end
        end
        c.imem_req  = (st == ST_FETCH);
        c.dmem_req  = (st == ST_MEM);
        c.dmem_we   = (st == ST_MEM) && (op == OP_SW);
        c.reg_write = (st == ST_WB);
        c.trap      = (st == ST_TRAP);
        return c;
    endfunction

endpackage

// File: rtl/mc_next_pc.sv
// mc_next_pc: combinational next-PC candidates.
//   pc_i       current PC (already advanced past the executing instruction)
//   idx_i      IR[25:0]; [15:0] is the branch immediate, all 26 bits the jump index
//   plus4_o    pc + 4
//   branch_o   pc + (sext(imm) << 2)
//   jump_o     {pc[31:28], idx, 2'b00}
// Targets are formed at 32 bits and truncated to PC_W (modulo 2^PC_W).
module mc_next_pc #(
    parameter int unsigned PC_W = 32
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [25:0]     idx_i,
    output logic [PC_W-1:0] plus4_o,
    output logic [PC_W-1:0] branch_o,
    output logic [PC_W-1:0] jump_o
);

    logic [31:0] pc32;
    logic [31:0] br_off;

    assign pc32     = 32'(pc_i);
    assign br_off   = {{14{idx_i[15]}}, idx_i[15:0], 2'b00};
    assign plus4_o  = PC_W'(pc32 + 32'd4);
    assign branch_o = PC_W'(pc32 + br_off);
    assign jump_o   = PC_W'({pc32[31:28], idx_i, 2'b00});

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle MIPS-subset sequencer owning PC and IR.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB with req/ready
// handshakes to variable-latency instruction and data memories, a memory
// wait timeout, an illegal-opcode trap and a retire pulse.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   imem_req/addr/ready/rdata     instruction fetch handshake
//   dmem_req/we/ready             data access handshake
//   zero                          ALU zero flag (branch condition)
//   instr                         latched instruction to the datapath
//   reg_dst/alu_src/mem_to_reg    datapath mux selects
//   alu_op, reg_write             ALU operation class, register write enable
//   retire                        pulse in the final cycle of an instruction
//   trap, trap_cause              sticky trap flag and its cause
module multicycle_sequencer
    import mc_pkg::*;
#(
    parameter int unsigned PC_W        = 32,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          EN_BNE      = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    input  logic            zero,
    output logic [XLEN-1:0] instr,
    output logic            reg_dst,
    output logic            alu_src,
    output logic            mem_to_reg,
    output logic [1:0]      alu_op,
    output logic            reg_write,
    output logic            retire,
    output logic            trap,
    output logic [1:0]      trap_cause
);

    localparam logic [PC_W-1:0]   RESET_PC_A = PC_W'(RESET_PC & 32'hFFFF_FFFC);
    localparam int unsigned       WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam bit                TMO_EN     = (MEM_TIMEOUT != 0);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        cause_q, cause_d;
    ctrl_t             ctrl_q;

    logic [OP_W-1:0]   opcode;
    logic [PC_W-1:0]   pc_plus4, pc_branch, pc_jump;
    logic              timeout_c;

    assign opcode = ir_q[31:26];

    // Not-ready cycle that would be the MEM_TIMEOUT-th consecutive one.
    assign timeout_c = TMO_EN && (wait_q == WAIT_LAST);

    mc_next_pc #(
        .PC_W (PC_W)
    ) u_next_pc (
        .pc_i     (pc_q),
        .idx_i    (ir_q[25:0]),
        .plus4_o  (pc_plus4),
        .branch_o (pc_branch),
        .jump_o   (pc_jump)
    );

    // Next-state, PC/IR update and wait-counter logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_plus4;
                    state_d = ST_DECODE;
                end else if (timeout_c) begin
                    cause_d = CAUSE_IMEM_TMO;
                    state_d = ST_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                if (!op_legal(opcode, EN_BNE)) begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = ST_TRAP;
                end else if (opcode == OP_J) begin
                    pc_d    = pc_jump;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OP_BEQ: begin
                        if (zero) pc_d = pc_branch;
                        state_d = ST_FETCH;
                    end
                    OP_BNE: begin
                        if (!zero) pc_d = pc_branch;
                        state_d = ST_FETCH;
                    end
                    OP_RTYPE, OP_ADDI: state_d = ST_WB;
                    OP_LW, OP_SW:      state_d = ST_MEM;
                    default:           state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_d = (opcode == OP_SW) ? ST_FETCH : ST_WB;
                end else if (timeout_c) begin
                    cause_d = CAUSE_DMEM_TMO;
                    state_d = ST_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) wait_d = '0;
    end

    // State, PC/IR and control registers; controls decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC_A;
            ir_q    <= '0;
            wait_q  <= '0;
            cause_q <= CAUSE_NONE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            ctrl_q  <= ctrl_decode(state_d, ir_d[31:26]);
        end
    end

    assign imem_req   = ctrl_q.imem_req;
    assign imem_addr  = pc_q;
    assign dmem_req   = ctrl_q.dmem_req;
    assign dmem_we    = ctrl_q.dmem_we;
    assign instr      = ir_q;
    assign reg_dst    = ctrl_q.reg_dst;
    assign alu_src    = ctrl_q.alu_src;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_op     = ctrl_q.alu_op;
    assign reg_write  = ctrl_q.reg_write;
    assign trap       = ctrl_q.trap;
    assign trap_cause = cause_q;

    // A store completes in MEM on the ready cycle itself, so retire must see dmem_ready.
    assign retire = (state_q == ST_WB)
                  || ((state_q == ST_DECODE) && (opcode == OP_J))
                  || ((state_q == ST_EXEC) && ((opcode == OP_BEQ) || (opcode == OP_BNE)))
                  || ((state_q == ST_MEM) && (opcode == OP_SW) && dmem_ready);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: self-checking bench. A fetch-address scoreboard
// is filled by each scenario and drained by the instruction-memory model;
// each scenario task checks its own cycle-accurate expectations.
module tb_multicycle_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: PC_W=32, RESET_PC=0, MEM_TIMEOUT=16, EN_BNE=1
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        dmem_req, dmem_we;
    logic        dmem_ready = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] instr;
    logic        reg_dst, alu_src, mem_to_reg, reg_write, retire, trap;
    logic [1:0]  alu_op, trap_cause;

    multicycle_sequencer #(
        .PC_W(32), .RESET_PC(32'h0), .MEM_TIMEOUT(16), .EN_BNE(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .zero(zero),
        .instr(instr), .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .reg_write(reg_write), .retire(retire), .trap(trap), .trap_cause(trap_cause)
    );

    // Second instance: PC_W=16, unaligned RESET_PC, no timeout, bne disabled
    logic        rst_b = 1'b0;
    logic        imem_req_b;
    logic [15:0] imem_addr_b;
    logic        imem_ready_b = 1'b0;
    logic [31:0] imem_rdata_b = 32'h0;
    logic        dmem_req_b, dmem_we_b;
    logic        dmem_ready_b = 1'b0;
    logic        zero_b = 1'b0;
    logic [31:0] instr_b;
    logic        reg_dst_b, alu_src_b, mem_to_reg_b, reg_write_b, retire_b, trap_b;
    logic [1:0]  alu_op_b, trap_cause_b;

    multicycle_sequencer #(
        .PC_W(16), .RESET_PC(32'h43), .MEM_TIMEOUT(0), .EN_BNE(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_b),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ready(imem_ready_b), .imem_rdata(imem_rdata_b),
        .dmem_req(dmem_req_b), .dmem_we(dmem_we_b), .dmem_ready(dmem_ready_b), .zero(zero_b),
        .instr(instr_b), .reg_dst(reg_dst_b), .alu_src(alu_src_b), .mem_to_reg(mem_to_reg_b),
        .alu_op(alu_op_b), .reg_write(reg_write_b), .retire(retire_b), .trap(trap_b), .trap_cause(trap_cause_b)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_fetch_q[$];
    logic [31:0] imem [0:63];
    int          imem_wait = 0;
    int          dmem_wait = 0;
    bit          imem_stuck = 1'b0;
    bit          dmem_stuck = 1'b0;
    int          i_cnt = 0;
    int          d_cnt = 0;
    logic [31:0] exp_a;

    // Memory models: ready after imem_wait/dmem_wait not-ready cycles of req.
    // Each accepted fetch is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            i_cnt = 0;
            d_cnt = 0;
        end else begin
            if (imem_req) begin
                if (!imem_stuck && i_cnt >= imem_wait) begin
                    imem_ready = 1'b1;
                    imem_rdata = imem[imem_addr[7:2]];
                    i_cnt = 0;
                    if (exp_fetch_q.size() > 0) begin
                        exp_a = exp_fetch_q.pop_front();
                        checks++;
                        if (imem_addr !== exp_a) begin
                            errors++;
                            $display("FAIL fetch_addr got=%h exp=%h t=%0t", imem_addr, exp_a, $time);
                        end
                    end
                end else begin
                    imem_ready = 1'b0;
                    i_cnt++;
                end
            end else begin
                imem_ready = 1'b0;
                i_cnt = 0;
            end
            if (dmem_req) begin
                if (!dmem_stuck && d_cnt >= dmem_wait) begin
                    dmem_ready = 1'b1;
                    d_cnt = 0;
                end else begin
                    dmem_ready = 1'b0;
                    d_cnt++;
                end
            end else begin
                dmem_ready = 1'b0;
                d_cnt = 0;
            end
        end
    end

    task automatic load_nops();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0000;
        imem_wait = 0; dmem_wait = 0; imem_stuck = 1'b0; dmem_stuck = 1'b0; zero = 1'b0;
    endtask

    // Hold reset, then release on a negedge; returns at the cycle-1 (IDLE) sample point.
    task automatic apply_reset();
        rst_n = 1'b0;
        exp_fetch_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (exp_fetch_q.size() != 0) begin
            errors++;
            $display("FAIL %s fetch_queue_left got=%0d exp=0", name, exp_fetch_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_b = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({imem_req, dmem_req, dmem_we, reg_dst, alu_src, mem_to_reg, alu_op, reg_write, retire, trap, trap_cause} !== 13'h0) begin
            errors++; $display("FAIL reset_ctrl got=%h exp=0", {imem_req, dmem_req, dmem_we, reg_dst, alu_src, mem_to_reg, alu_op, reg_write, retire, trap, trap_cause});
        end
        checks++;
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        checks++;
        if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instr); end
        checks++;
        if ({imem_req_b, dmem_req_b, dmem_we_b, reg_dst_b, alu_src_b, mem_to_reg_b, alu_op_b, reg_write_b, retire_b, trap_b, trap_cause_b, instr_b} !== 45'h0) begin
            errors++; $display("FAIL reset_b_outputs got=nonzero exp=0");
        end
        checks++;
        if (imem_addr_b !== 16'h0040) begin errors++; $display("FAIL reset_pc_align got=%h exp=0040", imem_addr_b); end
    endtask

    task automatic test_add_jump();
        logic [31:0] ret_mask, wb_mask;
        ret_mask = 0; wb_mask = 0;
        load_nops();
        imem[0] = 32'h0043_0820;   // add $1,$2,$3
        imem[1] = 32'h0800_0000;   // j 0
        apply_reset();
        exp_fetch_q.push_back(32'h0); exp_fetch_q.push_back(32'h4); exp_fetch_q.push_back(32'h0);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) next_cycle();
            if (retire === 1'b1) ret_mask[k] = 1'b1;
            if (reg_write === 1'b1) wb_mask[k] = 1'b1;
            if (k == 3) begin
                checks++;
                if (instr !== 32'h0043_0820) begin errors++; $display("FAIL add_ir got=%h exp=00430820", instr); end
            end
            if (k == 5) begin
                checks++;
                if ({reg_dst, alu_src, mem_to_reg, alu_op} !== 5'b10010) begin
                    errors++; $display("FAIL add_wb_ctrl got=%b exp=10010", {reg_dst, alu_src, mem_to_reg, alu_op});
                end
            end
        end
        checks++;
        if (ret_mask !== 32'h0000_00A0) begin errors++; $display("FAIL add_j_retire_cycles got=%h exp=000000a0", ret_mask); end
        checks++;
        if (wb_mask !== 32'h0000_0020) begin errors++; $display("FAIL add_reg_write_cycles got=%h exp=00000020", wb_mask); end
        check_sb_empty("add_jump");
    endtask

    task automatic test_lw_wait();
        int req_cycles, we_seen, ret_cyc;
        logic wb_ok;
        req_cycles = 0; we_seen = 0; ret_cyc = 0; wb_ok = 1'b0;
        load_nops();
        imem[0] = 32'h8C41_0000;   // lw $1,0($2)
        imem[1] = 32'h0800_0000;
        dmem_wait = 3;
        apply_reset();
        exp_fetch_q.push_back(32'h0); exp_fetch_q.push_back(32'h4);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) next_cycle();
            if (dmem_req === 1'b1) begin
                req_cycles++;
                if (dmem_we !== 1'b0 || alu_src !== 1'b1) we_seen++;
            end
            if (retire === 1'b1 && ret_cyc == 0) begin
                ret_cyc = k;
                wb_ok = (reg_write === 1'b1) && (mem_to_reg === 1'b1) && (reg_dst === 1'b0);
            end
        end
        checks++;
        if (req_cycles != 4) begin errors++; $display("FAIL lw_req_cycles got=%0d exp=4", req_cycles); end
        checks++;
        if (we_seen != 0) begin errors++; $display("FAIL lw_we_or_alusrc got=%0d bad exp=0", we_seen); end
        checks++;
        if (ret_cyc != 9) begin errors++; $display("FAIL lw_retire_cycle got=%0d exp=9", ret_cyc); end
        checks++;
        if (wb_ok !== 1'b1) begin errors++; $display("FAIL lw_wb_ctrl got=%b exp=1", wb_ok); end
        check_sb_empty("lw_wait");
    endtask

    task automatic test_sw();
        int ret_cyc, wr_seen, we_bad;
        ret_cyc = 0; wr_seen = 0; we_bad = 0;
        load_nops();
        imem[0] = 32'hAC41_0004;   // sw $1,4($2)
        imem[1] = 32'h0800_0000;
        dmem_wait = 1;
        apply_reset();
        exp_fetch_q.push_back(32'h0); exp_fetch_q.push_back(32'h4);
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) next_cycle();
            if (retire === 1'b1 && ret_cyc == 0) ret_cyc = k;
            if (reg_write === 1'b1) wr_seen++;
            if (dmem_req === 1'b1 && dmem_we !== 1'b1) we_bad++;
        end
        checks++;
        if (ret_cyc != 6) begin errors++; $display("FAIL sw_retire_cycle got=%0d exp=6", ret_cyc); end
        checks++;
        if (wr_seen != 0 || we_bad != 0) begin errors++; $display("FAIL sw_ctrl got=wr%0d/webad%0d exp=0/0", wr_seen, we_bad); end
        check_sb_empty("sw");
    endtask

    task automatic test_branch();
        logic [31:0] words [4];
        logic        zs    [4];
        logic [31:0] nxt   [4];
        logic        ex_ok;
        words[0] = 32'h1000_FFFF; zs[0] = 1'b1; nxt[0] = 32'h10;   // beq taken
        words[1] = 32'h1000_FFFF; zs[1] = 1'b0; nxt[1] = 32'h14;   // beq not taken
        words[2] = 32'h1400_FFFF; zs[2] = 1'b1; nxt[2] = 32'h14;   // bne not taken
        words[3] = 32'h1400_FFFF; zs[3] = 1'b0; nxt[3] = 32'h10;   // bne taken
        for (int t = 0; t < 4; t++) begin
            load_nops();
            imem[0] = 32'h0800_0004;   // j 0x10
            imem[4] = words[t];
            imem[5] = 32'h0800_0000;
            zero = zs[t];
            ex_ok = 1'b0;
            apply_reset();
            exp_fetch_q.push_back(32'h0); exp_fetch_q.push_back(32'h10); exp_fetch_q.push_back(nxt[t]);
            for (int k = 1; k <= 7; k++) begin
                if (k > 1) next_cycle();
                if (k == 6) ex_ok = (retire === 1'b1) && (alu_op === 2'b01) && (alu_src === 1'b0) && (reg_write === 1'b0);
            end
            checks++;
            if (ex_ok !== 1'b1) begin errors++; $display("FAIL branch%0d_exec_ctrl got=%b exp=1", t, ex_ok); end
            check_sb_empty("branch");
        end
    endtask

    task automatic test_illegal();
        int first_trap, req_after;
        first_trap = 0; req_after = 0;
        load_nops();
        imem[0] = 32'hFC00_0000;   // opcode 0x3F
        apply_reset();
        exp_fetch_q.push_back(32'h0);
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) next_cycle();
            if (trap === 1'b1 && first_trap == 0) first_trap = k;
            if (k >= 4 && imem_req !== 1'b0) req_after++;
        end
        checks++;
        if (first_trap != 4) begin errors++; $display("FAIL illegal_trap_cycle got=%0d exp=4", first_trap); end
        checks++;
        if (trap_cause !== 2'b01) begin errors++; $display("FAIL illegal_cause got=%b exp=01", trap_cause); end
        checks++;
        if (req_after != 0) begin errors++; $display("FAIL illegal_req_after_trap got=%0d exp=0", req_after); end
        checks++;
        if (imem_addr !== 32'h4 || instr !== 32'hFC00_0000) begin
            errors++; $display("FAIL illegal_frozen got=%h/%h exp=00000004/fc000000", imem_addr, instr);
        end
        check_sb_empty("illegal");
    endtask

    task automatic test_imem_timeout();
        int first_trap, trap_seen;
        first_trap = 0; trap_seen = 0;
        load_nops();
        imem_stuck = 1'b1;
        apply_reset();
        for (int k = 1; k <= 25; k++) begin
            if (k > 1) next_cycle();
            if (trap === 1'b1 && first_trap == 0) first_trap = k;
        end
        checks++;
        if (first_trap != 18) begin errors++; $display("FAIL imem_tmo_cycle got=%0d exp=18", first_trap); end
        checks++;
        if (trap_cause !== 2'b10 || imem_req !== 1'b0) begin
            errors++; $display("FAIL imem_tmo_state got=%b/%b exp=10/0", trap_cause, imem_req);
        end
        // Ready on the 16th wait cycle beats the timeout.
        load_nops();
        imem[0] = 32'h0043_0820;
        imem_wait = 15;
        apply_reset();
        exp_fetch_q.push_back(32'h0);
        for (int k = 1; k <= 18; k++) begin
            if (k > 1) next_cycle();
            if (trap === 1'b1) trap_seen++;
        end
        checks++;
        if (trap_seen != 0 || instr !== 32'h0043_0820) begin
            errors++; $display("FAIL ready_wins got=trap%0d/ir%h exp=0/00430820", trap_seen, instr);
        end
        check_sb_empty("ready_wins");
    endtask

    task automatic test_dmem_timeout();
        int first_trap;
        first_trap = 0;
        load_nops();
        imem[0] = 32'h8C41_0000;
        dmem_stuck = 1'b1;
        apply_reset();
        exp_fetch_q.push_back(32'h0);
        for (int k = 1; k <= 26; k++) begin
            if (k > 1) next_cycle();
            if (trap === 1'b1 && first_trap == 0) first_trap = k;
        end
        checks++;
        if (first_trap != 21) begin errors++; $display("FAIL dmem_tmo_cycle got=%0d exp=21", first_trap); end
        checks++;
        if (trap_cause !== 2'b11 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL dmem_tmo_state got=%b/%b exp=11/0", trap_cause, dmem_req);
        end
        check_sb_empty("dmem_timeout");
    endtask

    task automatic test_reset_mid_mem();
        load_nops();
        imem[0] = 32'h8C41_0000;
        dmem_wait = 20;
        apply_reset();
        exp_fetch_q.push_back(32'h0);
        for (int k = 2; k <= 6; k++) next_cycle();
        checks++;
        if (dmem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_pre got=%b exp=1", dmem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL mid_mem_reset_drop got=%b/%h exp=0/00000000", dmem_req, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL restart_idle got=%b exp=0", imem_req); end
        exp_fetch_q.push_back(32'h0);
        next_cycle();
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL restart_fetch got=%b exp=1", imem_req); end
        check_sb_empty("reset_mid_mem");
    endtask

    task automatic test_variant();
        imem_rdata_b = 32'h1400_FFFF;   // bne, illegal in this variant
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        imem_ready_b = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (trap_b !== 1'b1 || trap_cause_b !== 2'b01 || imem_req_b !== 1'b0) begin
            errors++; $display("FAIL bne_disabled got=%b/%b/%b exp=1/01/0", trap_b, trap_cause_b, imem_req_b);
        end
        rst_b = 1'b0;
        imem_ready_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        checks++;
        if (trap_b !== 1'b0 || imem_req_b !== 1'b1 || imem_addr_b !== 16'h0040) begin
            errors++; $display("FAIL no_timeout_wait got=%b/%b/%h exp=0/1/0040", trap_b, imem_req_b, imem_addr_b);
        end
    endtask

    initial begin
        #500000;
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_jump();
        test_lw_wait();
        test_sw();
        test_branch();
        test_illegal();
        test_imem_timeout();
        test_dmem_timeout();
        test_reset_mid_mem();
        test_variant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
